// File: rtl/arith_pkg.sv
// Shared types and helpers for the sequential arithmetic unit.
// Build option: define SEQ_ARITH_SATURATE_EN for clamping instead of wrapping.
package arith_pkg;

    localparam logic [1:0] OP_ADD_ENC = 2'b00;
    localparam logic [1:0] OP_SUB_ENC = 2'b01;
    localparam logic [1:0] OP_MUL_ENC = 2'b10;
    localparam logic [1:0] OP_ACC_ENC = 2'b11;

    localparam logic [1:0] S_IDLE_ENC = 2'd0;
    localparam logic [1:0] S_EXEC_ENC = 2'd1;
    localparam logic [1:0] S_MUL_ENC  = 2'd2;
    localparam logic [1:0] S_DONE_ENC = 2'd3;

    typedef enum logic [1:0] {
        OP_ADD = OP_ADD_ENC,
        OP_SUB = OP_SUB_ENC,
        OP_MUL = OP_MUL_ENC,
        OP_ACC = OP_ACC_ENC
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = S_IDLE_ENC,
        S_EXEC = S_EXEC_ENC,
        S_MUL  = S_MUL_ENC,
        S_DONE = S_DONE_ENC
    } state_t;

    // Two's-complement addition overflows when both inputs share a sign
    // and the wrapped result carries the opposite sign.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign,
                                     input logic r_sign);
        return (a_sign == b_sign) && (r_sign != a_sign);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// WIDTH cycles after load, finished held until the next load or reset.
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [WIDTH:0]     mag_a,
    input  logic [WIDTH:0]     mag_b,
    output logic [2*WIDTH-1:0] product,
    output logic               finished
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH:0]     mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    // Control: iteration counter and run/finished flags
    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= 1'b0;
            finished <= 1'b0;
            cnt      <= '0;
        end else if (load) begin
            run      <= 1'b1;
            finished <= 1'b0;
            cnt      <= '0;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
                run      <= 1'b0;
                finished <= 1'b1;
            end
        end
    end

    // Datapath: accumulate shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk) begin
        if (load) begin
            product <= '0;
            mcand   <= {{(WIDTH-1){1'b0}}, mag_a};
            mplier  <= mag_b;
        end else if (run) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
        end
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Clocked add/sub/mul/acc unit with start/done handshake.
// Build option: SEQ_ARITH_SATURATE_EN clamps overflowed results (and the
// accumulator) to the signed range instead of wrapping.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              op,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow,
    output logic                    busy,
    output logic                    done
);

    state_t                  state, state_nx;
    op_t                     op_q;
    logic signed [WIDTH-1:0] a_q, b_q, acc_q;
    logic                    neg_q;
    logic                    accept, commit, mul_load, mul_fin;
    logic [2*WIDTH-1:0]      product;
    logic signed [2*WIDTH-1:0] sprod;
    logic signed [WIDTH-1:0] raw_res, fin_res, sum_ab, diff_ab, sum_acc;
    logic                    raw_ovf;

    // Magnitude needs one extra bit so that -2^(WIDTH-1) stays positive.
    function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1], v};
        return v[WIDTH-1] ? -ext : ext;
    endfunction

    // Clamp value chosen by the sign of the true (unwrapped) result.
    function automatic logic signed [WIDTH-1:0] clamp(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign accept   = (state == S_IDLE) && start;
    assign mul_load = accept && (op_t'(op) == OP_MUL);
    assign commit   = (state == S_EXEC) || ((state == S_MUL) && mul_fin);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .load     (mul_load),
        .mag_a    (mag(a)),
        .mag_b    (mag(b)),
        .product  (product),
        .finished (mul_fin)
    );

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = (op_t'(op) == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: state_nx = S_DONE;
            S_MUL:  if (mul_fin) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Result selection, overflow detection and optional clamping
    always_comb begin
        sum_ab  = a_q + b_q;
        diff_ab = a_q - b_q;
        sum_acc = acc_q + a_q;
        sprod   = neg_q ? $signed(-product) : $signed(product);
        raw_res = sum_ab;
        raw_ovf = add_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sum_ab[WIDTH-1]);
        case (op_q)
            OP_SUB: begin
                raw_res = diff_ab;
                raw_ovf = add_ovf(a_q[WIDTH-1], ~b_q[WIDTH-1], diff_ab[WIDTH-1]);
            end
            OP_ACC: begin
                raw_res = sum_acc;
                raw_ovf = add_ovf(acc_q[WIDTH-1], a_q[WIDTH-1], sum_acc[WIDTH-1]);
            end
            OP_MUL: begin
                raw_res = sprod[WIDTH-1:0];
                raw_ovf = !((&sprod[2*WIDTH-1:WIDTH-1]) || !(|sprod[2*WIDTH-1:WIDTH-1]));
            end
            default: ;
        endcase
        fin_res = raw_res;
`ifdef SEQ_ARITH_SATURATE_EN
        if (raw_ovf) fin_res = clamp((op_q == OP_MUL) ? sprod[2*WIDTH-1] : a_q[WIDTH-1]);
`endif
    end

    // State, held result/overflow and accumulator
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            result   <= '0;
            overflow <= 1'b0;
            acc_q    <= '0;
        end else begin
            state <= state_nx;
            if (commit) begin
                result   <= fin_res;
                overflow <= raw_ovf;
                if (op_q == OP_ACC) acc_q <= fin_res;
            end
        end
    end

    // Operand capture on an accepted start only
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op_t'(op);
            a_q   <= a;
            b_q   <= b;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (WIDTH=8) with a cycle-level
// behavioural model compared every cycle plus literal expectations.
module tb_seq_arith_unit;

    localparam int W = 8;
    localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (W-1));

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          op = 2'b00;
    logic signed [W-1:0] a = '0, b = '0;
    logic signed [W-1:0] result;
    logic                overflow, busy, done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .result(result), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_res = 0, m_acc = 0, m_cnt = 0, p_res = 0;
    logic m_ovf = 0, m_busy = 0, m_done = 0, p_ovf = 0, p_acc = 0;

    function automatic void calc(input logic [1:0] o, input int av, input int bv,
                                 input int accv, output int r, output logic ov);
        longint full;
        logic signed [W-1:0] t;
        case (o)
            2'b00:   full = longint'(av) + bv;
            2'b01:   full = longint'(av) - bv;
            2'b10:   full = longint'(av) * bv;
            default: full = longint'(accv) + av;
        endcase
        ov = (full > MAXV) || (full < MINV);
        t = full[W-1:0];
        r = int'(t);
`ifdef SEQ_ARITH_SATURATE_EN
        if (ov) r = (full > 0) ? int'(MAXV) : int'(MINV);
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_res = 0; m_ovf = 0; m_acc = 0; m_busy = 0; m_done = 0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1; m_res = p_res; m_ovf = p_ovf;
                if (p_acc) m_acc = p_res;
            end
        end else if (start) begin
            calc(op, int'(a), int'(b), m_acc, p_res, p_ovf);
            p_acc  = (op == 2'b11);
            m_busy = 1;
            m_cnt  = (op == 2'b10) ? W + 1 : 1;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_busy", busy, m_busy);
            check("model_done", done, m_done);
            check("model_result", result, m_res);
            check("model_overflow", overflow, m_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input logic [1:0] o, input int av, input int bv,
                          input int exp_lat, input int exp_r, input logic exp_o,
                          input string nm);
        int k;
        @(negedge clk);
        start = 1'b1; op = o; a = av[W-1:0]; b = bv[W-1:0];
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy"}, busy, 1);
        k = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_done"}, done, 1);
        check({nm, "_lat"}, k, exp_lat);
        check({nm, "_res"}, result, exp_r);
        check({nm, "_ovf"}, overflow, exp_o);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    int  ndone;
    bit  sat;

    initial begin
`ifdef SEQ_ARITH_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        run_op(2'b00, 100, 27, 1, 127, 0, "add_127");
        run_op(2'b00, 100, 28, 1, sat ? 127 : -128, 1, "add_ovf");
        run_op(2'b01, -128, 1, 1, sat ? -128 : 127, 1, "sub_ovf");
        run_op(2'b01, 5, -3, 1, 8, 0, "sub_8");
        run_op(2'b10, -12, 10, W + 1, -120, 0, "mul_m120");
        run_op(2'b10, 16, 8, W + 1, sat ? 127 : -128, 1, "mul_128");
        run_op(2'b10, -128, -1, W + 1, sat ? 127 : -128, 1, "mul_min");

        do_reset();
        run_op(2'b11, 100, 0, 1, 100, 0, "acc1");
        run_op(2'b11, 100, 0, 1, sat ? 127 : -56, 1, "acc2");
        run_op(2'b11, 100, 0, 1, sat ? 127 : 44, sat, "acc3");

        // start held high through a multiply; operands change meanwhile
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'sd3; b = 8'sd4;
        @(negedge clk);
        op = 2'b00; a = 8'sd5; b = 8'sd5;
        ndone = 0;
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("pulse_ndone", ndone, 1);
        check("pulse_res", result, 12);
        @(negedge clk);
        check("pulse_idle_busy", busy, 0);
        @(negedge clk);
        check("pulse_accept_busy", busy, 1);
        start = 1'b0;
        @(negedge clk);
        check("pulse_add_done", done, 1);
        check("pulse_add_res", result, 10);
        @(negedge clk);

        // reset during a multiply aborts it
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 8'sd7; b = 8'sd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", result, 0);
        check("abort_ovf", overflow, 0);
        check("abort_busy", busy, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_op(2'b00, 1, 1, 1, 2, 0, "add_after_abort");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
